// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared widths, depths and serializer state for the piso/sipo pair
package sipo_pkg;

  // Parallel word width and queue depth shared by both ends of the serial link
  localparam int PISO_WIDTH = 32;
  localparam int PISO_DEPTH = 4;

  // The deserializer derives its geometry from the serializer so the two always agree
  localparam int SIPO_WIDTH = PISO_WIDTH;
  localparam int SIPO_DEPTH = PISO_DEPTH;

  // Serializer control states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Bit counter must hold the value WIDTH itself, hence one extra bit
  function automatic int bitcnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/piso_fifo.sv
// rtl/piso_fifo.sv - single-clock word queue with registered occupancy count
module piso_fifo
  import sipo_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH,
  parameter int DEPTH = PISO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Status comes from the registered count only, so a word written this
  // cycle cannot be seen at the head until the following edge.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/piso.sv
// rtl/piso.sv - queued parallel-in serial-out shifter, LSB first, with pause and underrun
module piso
  import sipo_pkg::*;
#(
  parameter int   WIDTH    = PISO_WIDTH,
  parameter int   DEPTH    = PISO_DEPTH,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int BW = bitcnt_width(WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] head_data;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  ser_state_e       state_q,  state_d;
  logic [WIDTH-1:0] shreg_q,  shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             sout_d;
  logic             sout_valid_d;
  logic             underrun_d;
  logic             load;

  // Readiness is a pure function of the registered count, held low in reset
  assign in_ready = (fifo_count < CW'(DEPTH)) && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = load;
  assign busy     = (state_q == SHIFT) || !fifo_empty;

  piso_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Next-state logic: everything holds unless enabled; valid and underrun default low
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    sout_d       = sout;
    sout_valid_d = 1'b0;
    underrun_d   = 1'b0;
    load         = 1'b0;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            load = 1'b1;
          end
        end
        SHIFT: begin
          if (bitcnt_q < BW'(WIDTH)) begin
            sout_d       = shreg_q[0];
            shreg_d      = shreg_q >> 1;
            bitcnt_d     = bitcnt_q + BW'(1);
            sout_valid_d = 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next word so there is no gap bit
            load = 1'b1;
          end else begin
            state_d    = IDLE;
            sout_d     = IDLE_BIT;
            underrun_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // A load puts bit 0 on the line and keeps the remainder for shifting
      if (load) begin
        sout_d       = head_data[0];
        shreg_d      = head_data >> 1;
        bitcnt_d     = BW'(1);
        sout_valid_d = 1'b1;
        state_d      = SHIFT;
      end
    end
  end

  // State, shifter and registered outputs; reset discards any partial word silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      sout       <= IDLE_BIT;
      sout_valid <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      sout       <= sout_d;
      sout_valid <= sout_valid_d;
      underrun   <= underrun_d;
    end
  end

endmodule
